kgp_imem_loader: RTL and testbench
==================================

# kgp_imem_loader

Program loader for the KGP_RISC core: accepts a stream of 32-bit instruction words over a valid/ready handshake, writes them sequentially into the core's instruction memory, holds the core in reset while loading, then releases reset so execution starts at address 0. It is the write-side counterpart to the bench and monitor logic that reset the core and read its `out` port. It replaces ad-hoc memory initialisation in simulation and on the board.

## Interface
Parameters:
- ADDR_W, 10, instruction memory word-address width; depth = 2**ADDR_W words
- RST_HOLD, 4, cycles `cpu_rst` stays high after the final write (range 1..15)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately; release is synchronous to clk)
- start  in  1  begin a load session; sampled in IDLE and RUN only
- in_valid  in  1  source has a word on in_data
- in_data  in  32  instruction word
- in_last  in  1  qualifies the final word of the program
- in_ready  out  1  loader accepts a word this cycle
- imem_we  out  1  instruction memory write enable
- imem_addr  out  ADDR_W  instruction memory word address
- imem_wdata  out  32  instruction memory write data
- cpu_rst  out  1  active-high reset to KGP_RISC
- done  out  1  program loaded and core released
- err  out  1  overflow: memory filled before in_last
- word_count  out  ADDR_W+1  words written in the current or last session

## Operation
- States: IDLE, LOAD, HOLD, RUN.
- IDLE: cpu_rst=1, in_ready=0. start=1 -> LOAD; clear word_count, err and done; set the write pointer to 0.
- LOAD: in_ready=1. Handshake = in_valid & in_ready. On a handshake, register in_data and the pointer into imem_wdata/imem_addr, pulse imem_we, increment the pointer and word_count.
  - Handshake with in_last=1 -> HOLD.
  - Handshake at pointer = 2**ADDR_W-1 with in_last=0 -> err=1, HOLD. The word is still written and the pointer does not wrap.
  - start is ignored in LOAD.
- HOLD: in_ready=0, cpu_rst=1. A counter runs RST_HOLD cycles, then -> RUN.
- RUN: cpu_rst=0, done=1, in_ready=0. start=1 -> LOAD, with cpu_rst reasserted and done cleared in the same transition.
- err stays set through RUN until the next start. done=1 only in RUN.
- in_data and in_last are ignored outside handshake cycles.
- rst=0 in any state aborts to IDLE. Partially written memory is not cleared.

## Timing
- Reset values:
  - Outputs: cpu_rst=1, in_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, done=0, err=0, word_count=0.
  - State: IDLE.
- All outputs are registered. No combinational path from inputs to outputs.
- start in IDLE at edge N -> in_ready=1 after edge N.
- Handshake at edge N -> imem_we=1 with addr/data valid for the cycle after edge N. One write per handshake, so the loader sustains one word per cycle.
- Last handshake at edge N -> in_ready=0 after edge N. cpu_rst falls after edge N+RST_HOLD+1, with done=1 after the same edge.
- The final imem_we pulse completes before cpu_rst falls.
- in_valid held low in LOAD -> no writes, state unchanged, no timeout.
- start and in_valid both high on the RUN->LOAD edge: start is taken; no word is accepted until the next cycle.

## Test plan
- Reset: assert rst=0 mid-stream, then release. Required: all outputs at reset values, state IDLE, cpu_rst=1.
- Basic load: start, then 3 words 0x20010005, 0x20020003, 0x00221820 (last on the third), in_valid held high. Required: writes at addr 0,1,2 on consecutive cycles; word_count=3; cpu_rst falls RST_HOLD+1 cycles after the third handshake; done=1, err=0.
- Backpressure gaps: toggle in_valid 1,0,0,1,1 with in_last on the final word. Required: exactly 3 writes at addr 0,1,2 and no spurious imem_we.
- Overflow with ADDR_W=2: send 5 words, none marked last. Required: 4 writes at addr 0..3; err=1 after the 4th handshake; 5th word not accepted (in_ready=0); done=1 with err=1 in RUN.
- Reload: in RUN, pulse start, then load 1 word 0xFFFFFFFF marked last. Required: cpu_rst=1 the cycle after start; write at addr 0; word_count=1; done returns after RST_HOLD+1 cycles.
- start asserted in LOAD and HOLD. Required: no effect on state, pointer or word_count.

Source files
------------

// File: rtl/kgp_imem_loader_if.sv
// Program stream in (valid/ready, last-qualified) and instruction-memory write bus out.
// Width of the memory address follows the loader's ADDR_W.
interface kgp_imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic              in_valid;
  logic [31:0]       in_data;
  logic              in_last;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output in_valid, in_data, in_last,
    input  in_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/kgp_imem_loader.sv
// Streams a program into KGP_RISC instruction memory, one registered write per accepted word,
// then holds the core in reset for RST_HOLD+1 cycles after the last write; in_ready drops outside LOAD.
module kgp_imem_loader #(
  parameter int ADDR_W   = 10,
  parameter int RST_HOLD = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  kgp_imem_loader_if.slave  bus,
  output logic              cpu_rst,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  localparam logic [3:0] HOLD_LAST = 4'(RST_HOLD);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [3:0]        hold, hold_nxt;
  logic              ready, ready_nxt;
  logic              we, we_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [31:0]       wdata, wdata_nxt;
  logic              cpu_rst_nxt, done_nxt, err_nxt;
  logic [ADDR_W:0]   count_nxt;
  logic              hs, full;

  assign hs   = bus.in_valid & ready;
  assign full = (ptr == {ADDR_W{1'b1}});

  always_comb begin
    state_nxt   = state;
    ptr_nxt     = ptr;
    hold_nxt    = hold;
    ready_nxt   = ready;
    we_nxt      = 1'b0;
    addr_nxt    = addr;
    wdata_nxt   = wdata;
    cpu_rst_nxt = cpu_rst;
    done_nxt    = done;
    err_nxt     = err;
    count_nxt   = word_count;
    case (state)
      IDLE, RUN: begin
        if (start) begin
          state_nxt   = LOAD;
          ready_nxt   = 1'b1;
          cpu_rst_nxt = 1'b1;
          done_nxt    = 1'b0;
          err_nxt     = 1'b0;
          count_nxt   = '0;
          ptr_nxt     = '0;
        end
      end
      LOAD: begin
        if (hs) begin
          we_nxt    = 1'b1;
          addr_nxt  = ptr;
          wdata_nxt = bus.in_data;
          count_nxt = word_count + (ADDR_W+1)'(1);
          if (bus.in_last || full) begin
            // The final slot is still written; the pointer parks instead of wrapping.
            state_nxt = HOLD;
            ready_nxt = 1'b0;
            hold_nxt  = '0;
            err_nxt   = ~bus.in_last;
          end else begin
            ptr_nxt = ptr + ADDR_W'(1);
          end
        end
      end
      HOLD: begin
        if (hold == HOLD_LAST) begin
          state_nxt   = RUN;
          cpu_rst_nxt = 1'b0;
          done_nxt    = 1'b1;
        end else begin
          hold_nxt = hold + 4'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      ptr        <= '0;
      hold       <= '0;
      ready      <= 1'b0;
      we         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      cpu_rst    <= 1'b1;
      done       <= 1'b0;
      err        <= 1'b0;
      word_count <= '0;
    end else begin
      state      <= state_nxt;
      ptr        <= ptr_nxt;
      hold       <= hold_nxt;
      ready      <= ready_nxt;
      we         <= we_nxt;
      addr       <= addr_nxt;
      wdata      <= wdata_nxt;
      cpu_rst    <= cpu_rst_nxt;
      done       <= done_nxt;
      err        <= err_nxt;
      word_count <= count_nxt;
    end
  end

  assign bus.in_ready   = ready;
  assign bus.imem_we    = we;
  assign bus.imem_addr  = addr;
  assign bus.imem_wdata = wdata;

endmodule

// File: tb/tb_kgp_imem_loader.sv
// Program-loader bench: directed sessions plus random programs, scored against an expected memory image.
module tb_kgp_imem_loader;
  localparam int AW    = 2;
  localparam int DEPTH = 1 << AW;
  localparam int RH    = 4;

  logic clk   = 1'b0;
  logic rst   = 1'b1;
  logic start = 1'b0;
  logic cpu_rst, done, err;
  logic [AW:0] word_count;

  kgp_imem_loader_if #(.ADDR_W(AW)) bus ();

  kgp_imem_loader #(.ADDR_W(AW), .RST_HOLD(RH)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus),
    .cpu_rst(cpu_rst), .done(done), .err(err), .word_count(word_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  wr_t         wq[$];
  int          hold_viol = 0;
  int          chk = 0;
  int          errs = 0;
  logic [31:0] prog [8];

  // Every memory write is logged; a write while the core runs is a violation.
  always @(negedge clk) begin
    if (bus.imem_we === 1'b1) begin
      wq.push_back('{bus.imem_addr, bus.imem_wdata});
      if (cpu_rst !== 1'b1) hold_viol++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input string what, input logic [63:0] obs, input logic [63:0] exp);
    chk++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s.%s observed=%0h expected=%0h", tag, what, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check(tag, "in_ready", bus.in_ready, 0);
    check(tag, "imem_we", bus.imem_we, 0);
    check(tag, "imem_addr", bus.imem_addr, 0);
    check(tag, "imem_wdata", bus.imem_wdata, 0);
    check(tag, "cpu_rst", cpu_rst, 1);
    check(tag, "done", done, 0);
    check(tag, "err", err, 0);
    check(tag, "word_count", word_count, 0);
  endtask

  // One load session starting from IDLE or RUN. pat_len>0 gives a fixed in_valid pattern.
  task automatic session(input string tag, input int n, input bit with_last,
                         input logic [31:0] pat, input int pat_len, input bit poke);
    int idx = 0, k = 0, guard = 0, rdy_bad = 0, hold_bad = 0, exp_acc;
    bit exp_err, fin = 0, hs, lastw;
    exp_acc = (with_last && n <= DEPTH) ? n : DEPTH;
    exp_err = !(with_last && n <= DEPTH);

    start = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = $urandom;
    bus.in_last  = 1'b1;
    step();
    start = 1'b0;
    wq.delete();
    check(tag, "start_in_ready", bus.in_ready, 1);
    check(tag, "start_cpu_rst", cpu_rst, 1);
    check(tag, "start_done", done, 0);
    check(tag, "start_err", err, 0);
    check(tag, "start_word_count", word_count, 0);

    while (!fin && guard < 200) begin
      guard++;
      if (pat_len > 0) bus.in_valid = pat[(guard-1) % pat_len];
      else             bus.in_valid = ($urandom_range(99) >= 30);
      lastw        = with_last && (idx == n-1);
      bus.in_data  = bus.in_valid ? prog[idx % 8] : $urandom;
      bus.in_last  = bus.in_valid ? lastw : 1'($urandom_range(1));
      if (poke) start = 1'($urandom_range(1));
      if (bus.in_ready !== 1'b1) rdy_bad++;
      hs = bus.in_valid;
      step();
      if (hs) begin
        idx++;
        if (lastw || idx == DEPTH) fin = 1;
      end
    end
    check(tag, "accepted", idx, exp_acc);
    check(tag, "ready_while_loading", rdy_bad, 0);
    check(tag, "in_ready_after_last", bus.in_ready, 0);
    check(tag, "err_after_last", err, exp_err);

    // Junk on the input during HOLD must never be written.
    while (done !== 1'b1 && k < 40) begin
      bus.in_valid = 1'($urandom_range(1));
      bus.in_data  = $urandom;
      bus.in_last  = 1'($urandom_range(1));
      if (poke) start = 1'($urandom_range(1));
      if (cpu_rst !== 1'b1 || bus.in_ready !== 1'b0) hold_bad++;
      step();
      k++;
    end
    start        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    check(tag, "release_latency", k, RH + 1);
    check(tag, "held_in_reset", hold_bad, 0);
    check(tag, "done", done, 1);
    check(tag, "cpu_rst", cpu_rst, 0);
    check(tag, "err", err, exp_err);
    check(tag, "word_count", word_count, exp_acc);
    check(tag, "writes", wq.size(), exp_acc);
    for (int i = 0; i < wq.size() && i < exp_acc; i++) begin
      check(tag, $sformatf("addr%0d", i), wq[i].addr, i);
      check(tag, $sformatf("data%0d", i), wq[i].data, prog[i]);
    end
    check(tag, "write_while_running", hold_viol, 0);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.in_last  = 1'b0;
    #2 rst = 1'b0;
    #1 check_reset("por");
    step();
    step();
    rst = 1'b1;
    step();
    check_reset("idle");

    prog[0] = 32'h20010005; prog[1] = 32'h20020003; prog[2] = 32'h00221820;
    session("basic", 3, 1'b1, 32'h1, 1, 1'b0);

    prog[0] = 32'hA0000001; prog[1] = 32'hA0000002; prog[2] = 32'hA0000003;
    session("gaps", 3, 1'b1, 32'b11001, 5, 1'b0);

    prog[0] = 32'hFFFFFFFF;
    session("reload", 1, 1'b1, 32'h1, 1, 1'b0);

    for (int i = 0; i < 5; i++) prog[i] = 32'hC0DE0000 + i;
    session("overflow", 5, 1'b0, 32'h1, 1, 1'b0);

    for (int i = 0; i < 3; i++) prog[i] = $urandom;
    session("start_ignored", 3, 1'b1, 32'h0, 0, 1'b1);

    // Abort in the middle of a load.
    start = 1'b1;
    step();
    start = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h12345678;
    bus.in_last  = 1'b0;
    step();
    step();
    #2 rst = 1'b0;
    bus.in_valid = 1'b0;
    #1 check_reset("abort");
    step();
    rst = 1'b1;
    step();
    check_reset("abort_idle");

    prog[0] = 32'h0BADF00D; prog[1] = 32'h00000001;
    session("after_abort", 2, 1'b1, 32'h0, 0, 1'b0);

    for (int r = 0; r < 20; r++) begin
      bit wl;
      int n;
      wl = 1'($urandom_range(1));
      n  = wl ? int'($urandom_range(1, DEPTH)) : DEPTH + int'($urandom_range(0, 2));
      for (int i = 0; i < 8; i++) prog[i] = $urandom;
      session($sformatf("rnd%0d", r), n, wl, 32'h0, 0, 1'($urandom_range(1)));
    end

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end
endmodule
